// File: rtl/uart_frame_link.sv
// UART framing transceiver: bursts a payload MSB-byte first on rs232_tx and collects
// terminator-delimited frames from rs232_rx into a snapshot buffer.
module uart_frame_link #(
  parameter int unsigned CLK_DIV  = 1250,
  parameter int unsigned TX_WIDTH = 12,
  parameter int unsigned RX_DEPTH = 120,
  parameter logic [7:0]  TERM     = 8'h1F,
  localparam int unsigned LEN_W   = $clog2(RX_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_start,
  input  logic [TX_WIDTH-1:0]   tx_payload,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic                  rs232_tx,
  input  logic                  rs232_rx,
  output logic [RX_DEPTH*8-1:0] rx_frame,
  output logic [LEN_W-1:0]      rx_len,
  output logic                  rx_done,
  output logic                  rx_overflow,
  output logic                  rx_frame_err
);

  localparam int unsigned N_TX  = (TX_WIDTH + 7) / 8;
  localparam int unsigned PAY_W = N_TX * 8;
  localparam int unsigned NB_W  = (N_TX > 1) ? $clog2(N_TX) : 1;
  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned BUF_W = RX_DEPTH * 8;

  localparam logic [CNT_W-1:0] BitLast = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BitHalf = CNT_W'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  tx_state_e         tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [NB_W-1:0]   tx_byte_q, tx_byte_d;
  logic [7:0]        tx_sh_q, tx_sh_d;
  logic [PAY_W-1:0]  tx_pay_q, tx_pay_d;
  logic              tx_done_q, tx_done_d;
  logic [PAY_W-1:0]  pay_ext;
  logic              tx_bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      tx_sh_q    <= '0;
      tx_pay_q   <= '0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      tx_sh_q    <= tx_sh_d;
      tx_pay_q   <= tx_pay_d;
      tx_done_q  <= tx_done_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    tx_sh_d    = tx_sh_q;
    tx_pay_d   = tx_pay_q;
    tx_done_d  = 1'b0;
    pay_ext    = PAY_W'(tx_payload);
    tx_bit_end = (tx_cnt_q == BitLast);
    tx_cnt_d   = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    unique case (tx_state_q)
      TxIdle: begin
        tx_cnt_d = '0;
        if (tx_start) begin
          tx_state_d = TxStart;
          tx_bit_d   = '0;
          tx_byte_d  = NB_W'(N_TX - 1);
          tx_sh_d    = pay_ext[PAY_W-1 -: 8];
          tx_pay_d   = pay_ext << 8;
        end
      end
      TxStart: begin
        if (tx_bit_end) tx_state_d = TxData;
      end
      TxData: begin
        if (tx_bit_end) begin
          tx_sh_d  = tx_sh_q >> 1;
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = TxStop;
        end
      end
      TxStop: begin
        if (tx_bit_end) begin
          if (tx_byte_q == '0) begin
            tx_state_d = TxIdle;
            tx_done_d  = 1'b1;
          end else begin
            // Next byte follows directly, no idle bit between bytes of a burst.
            tx_state_d = TxStart;
            tx_byte_d  = tx_byte_q - 1'b1;
            tx_sh_d    = tx_pay_q[PAY_W-1 -: 8];
            tx_pay_d   = tx_pay_q << 8;
          end
        end
      end
    endcase
  end

  always_comb begin
    unique case (tx_state_q)
      TxStart: rs232_tx = 1'b0;
      TxData:  rs232_tx = tx_sh_q[0];
      default: rs232_tx = 1'b1;
    endcase
  end

  assign tx_busy = (tx_state_q != TxIdle);
  assign tx_done = tx_done_q;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic [1:0]        sync_q;
  logic              rx_prev_q;
  logic              rx_s;
  rx_state_e         rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_sh_q, rx_sh_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [LEN_W-1:0]  wcnt_q, wcnt_d;
  logic              sticky_q, sticky_d;
  logic [BUF_W-1:0]  frame_q, frame_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  assign rx_s = sync_q[1];

  // Synchroniser resets to the idle level so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rs232_rx};
      rx_prev_q <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      buf_q      <= '0;
      wcnt_q     <= '0;
      sticky_q   <= 1'b0;
      frame_q    <= '0;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      buf_q      <= buf_d;
      wcnt_q     <= wcnt_d;
      sticky_q   <= sticky_d;
      frame_q    <= frame_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    buf_d      = buf_q;
    wcnt_d     = wcnt_q;
    sticky_d   = sticky_q;
    frame_d    = frame_q;
    len_d      = len_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s) rx_state_d = RxStart;
      end
      RxStart: begin
        if (rx_cnt_q == BitHalf) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BitLast) begin
          rx_state_d = RxIdle;
          rx_cnt_d   = '0;
          if (!rx_s) begin
            err_d = 1'b1;
          end else if (rx_sh_q == TERM) begin
            frame_d  = buf_q;
            len_d    = wcnt_q;
            ovf_d    = sticky_q;
            done_d   = 1'b1;
            buf_d    = '0;
            wcnt_d   = '0;
            sticky_d = 1'b0;
          end else if (wcnt_q < LEN_W'(RX_DEPTH)) begin
            buf_d  = (buf_q << 8) | BUF_W'(rx_sh_q);
            wcnt_d = wcnt_q + 1'b1;
          end else begin
            sticky_d = 1'b1;
          end
        end
      end
    endcase
  end

  assign rx_frame     = frame_q;
  assign rx_len       = len_q;
  assign rx_overflow  = ovf_q;
  assign rx_done      = done_q;
  assign rx_frame_err = err_q;

endmodule

// File: tb/tb_uart_frame_link.sv
// Directed bench for uart_frame_link with CLK_DIV=16, TX_WIDTH=12, RX_DEPTH=4, TERM=8'h1F.
module tb_uart_frame_link;

  localparam int unsigned CLK_DIV  = 16;
  localparam int unsigned TX_WIDTH = 12;
  localparam int unsigned RX_DEPTH = 4;
  localparam int unsigned LEN_W    = $clog2(RX_DEPTH + 1);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  tx_start = 1'b0;
  logic [TX_WIDTH-1:0]   tx_payload = '0;
  logic                  tx_busy;
  logic                  tx_done;
  logic                  rs232_tx;
  logic                  rs232_rx = 1'b1;
  logic [RX_DEPTH*8-1:0] rx_frame;
  logic [LEN_W-1:0]      rx_len;
  logic                  rx_done;
  logic                  rx_overflow;
  logic                  rx_frame_err;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  uart_frame_link #(
    .CLK_DIV (CLK_DIV),
    .TX_WIDTH(TX_WIDTH),
    .RX_DEPTH(RX_DEPTH),
    .TERM    (8'h1F)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_start    (tx_start),
    .tx_payload  (tx_payload),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .rs232_tx    (rs232_tx),
    .rs232_rx    (rs232_rx),
    .rx_frame    (rx_frame),
    .rx_len      (rx_len),
    .rx_done     (rx_done),
    .rx_overflow (rx_overflow),
    .rx_frame_err(rx_frame_err)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge; a 2-cycle pulse counts twice.
  always @(negedge clk) begin
    if (rx_done) done_cnt++;
    if (rx_frame_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rs232_rx = 1'b0;
    cycles(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      rs232_rx = b[i];
      cycles(CLK_DIV);
    end
    rs232_rx = stop;
    cycles(CLK_DIV);
    rs232_rx = 1'b1;
    cycles(4);
  endtask

  // Sends one burst and checks line bits at mid-bit, plus busy/done timing. A non-zero
  // ign cycle issues an extra tx_start mid-burst which must have no effect.
  task automatic tx_run(input logic [11:0] pay, input logic [7:0] exp_hi,
                        input logic [7:0] exp_lo, input int ign);
    logic [19:0] bits;
    bits = '0;
    tx_payload = pay;
    tx_start = 1'b1;
    cycles(1);
    tx_start = 1'b0;
    for (int cyc = 1; cyc <= 325; cyc++) begin
      if (cyc == 1) begin
        check("tx_busy_c1", 64'(tx_busy), 64'd1);
        check("tx_line_c1", 64'(rs232_tx), 64'd0);
      end
      if (cyc <= 320 && ((cyc - 1) % 16) == 8) bits[(cyc - 1) / 16] = rs232_tx;
      if (cyc == ign) begin
        tx_payload = 12'h0F0;
        tx_start = 1'b1;
      end else begin
        tx_start = 1'b0;
      end
      if (cyc == 320) begin
        check("tx_done_c320", 64'(tx_done), 64'd0);
        check("tx_busy_c320", 64'(tx_busy), 64'd1);
      end
      if (cyc == 321) begin
        check("tx_done_c321", 64'(tx_done), 64'd1);
        check("tx_busy_c321", 64'(tx_busy), 64'd0);
      end
      if (cyc == 322) check("tx_done_c322", 64'(tx_done), 64'd0);
      if (cyc == 325) begin
        check("tx_busy_after", 64'(tx_busy), 64'd0);
        check("tx_line_after", 64'(rs232_tx), 64'd1);
      end
      cycles(1);
    end
    check("tx_byte_hi", 64'(bits[8:1]), 64'(exp_hi));
    check("tx_byte_lo", 64'(bits[18:11]), 64'(exp_lo));
    check("tx_framing", 64'({bits[0], bits[9], bits[10], bits[19]}), 64'b0101);
  endtask

  initial begin
    // Reset state
    cycles(3);
    check("rst_tx_line", 64'(rs232_tx), 64'd1);
    check("rst_tx_busy", 64'(tx_busy), 64'd0);
    check("rst_tx_done", 64'(tx_done), 64'd0);
    check("rst_rx_frame", 64'(rx_frame), 64'd0);
    check("rst_rx_len", 64'(rx_len), 64'd0);
    check("rst_rx_flags", 64'({rx_done, rx_overflow, rx_frame_err}), 64'd0);
    rst = 1'b0;
    cycles(3);

    // TX burst with an ignored mid-burst request
    tx_run(12'hABC, 8'h0A, 8'hBC, 100);

    // RX frame
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h1F, 1'b1);
    cycles(4);
    check("frm_done_cnt", 64'(done_cnt), 64'd1);
    check("frm_len", 64'(rx_len), 64'd2);
    check("frm_data", 64'(rx_frame[15:0]), 64'h1122);
    check("frm_ovf", 64'(rx_overflow), 64'd0);

    // RX overflow
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b1);
    send_byte(8'h1F, 1'b1);
    cycles(4);
    check("ovf_done_cnt", 64'(done_cnt), 64'd2);
    check("ovf_len", 64'(rx_len), 64'd4);
    check("ovf_data", 64'(rx_frame[31:0]), 64'h01020304);
    check("ovf_flag", 64'(rx_overflow), 64'd1);

    // Empty frame, also clears overflow
    send_byte(8'h1F, 1'b1);
    cycles(4);
    check("empty_done_cnt", 64'(done_cnt), 64'd3);
    check("empty_len", 64'(rx_len), 64'd0);
    check("empty_ovf", 64'(rx_overflow), 64'd0);

    // Glitch and bad stop bit must not disturb the working buffer
    send_byte(8'hAA, 1'b1);
    rs232_rx = 1'b0;
    cycles(4);
    rs232_rx = 1'b1;
    cycles(40);
    check("glitch_no_done", 64'(done_cnt), 64'd3);
    check("glitch_no_err", 64'(err_cnt), 64'd0);
    send_byte(8'h55, 1'b0);
    cycles(4);
    check("badstop_err", 64'(err_cnt), 64'd1);
    send_byte(8'h1F, 1'b1);
    cycles(4);
    check("err_done_cnt", 64'(done_cnt), 64'd4);
    check("err_len", 64'(rx_len), 64'd1);
    check("err_data", 64'(rx_frame[7:0]), 64'hAA);
    check("err_ovf", 64'(rx_overflow), 64'd0);

    // Asynchronous reset mid-TX and mid-RX byte
    tx_payload = 12'h777;
    tx_start = 1'b1;
    cycles(1);
    tx_start = 1'b0;
    rs232_rx = 1'b0;
    cycles(40);
    check("pre_rst_busy", 64'(tx_busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_tx_line", 64'(rs232_tx), 64'd1);
    check("arst_tx_busy", 64'(tx_busy), 64'd0);
    check("arst_rx_frame", 64'(rx_frame), 64'd0);
    check("arst_rx_len", 64'(rx_len), 64'd0);
    check("arst_flags", 64'({tx_done, rx_done, rx_overflow, rx_frame_err}), 64'd0);
    rs232_rx = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(3);

    // Full-duplex exchange after reset
    fork
      tx_run(12'h5A5, 8'h05, 8'hA5, 0);
      begin
        send_byte(8'h77, 1'b1);
        send_byte(8'h1F, 1'b1);
      end
    join
    cycles(4);
    check("dup_done_cnt", 64'(done_cnt), 64'd5);
    check("dup_len", 64'(rx_len), 64'd1);
    check("dup_data", 64'(rx_frame[7:0]), 64'h77);
    check("dup_err_cnt", 64'(err_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
